// File: rtl/fft_host_bridge.sv
// Register-mapped host bridge for the iterative FFT core.
// Input sample latch/push, buffered result FIFO, counters, sticky status, IRQ.
module fft_host_bridge #(
    parameter int DWL     = 16,
    parameter int AWL     = 10,
    parameter int FIFO_AW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [2:0]     ADDR,
    input  logic           WR,
    input  logic           RD,
    input  logic [DWL-1:0] WDATA,
    output logic [DWL-1:0] RDATA,
    output logic           IRQ,
    output logic [DWL-1:0] o_DATA_R,
    output logic [DWL-1:0] o_DATA_I,
    output logic           o_WR_DATA,
    input  logic           i_FULL,
    input  logic [DWL-1:0] i_DATA_R,
    input  logic [DWL-1:0] i_DATA_I,
    input  logic           i_VALID
);

    localparam int CW    = AWL + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] FRAME = {1'b1, {AWL{1'b0}}};

    // control / status state
    logic          push_on_imag;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          in_ovf;
    logic          out_ovf;
    logic          frame_done;

    // result FIFO
    logic [2*DWL-1:0] mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic [2*DWL-1:0] head;

    // decoded strobes
    logic          wr_in_r;
    logic          wr_in_i;
    logic          wr_status;
    logic          wr_ctrl;
    logic          push_req;
    logic          soft_clr;
    logic          push_ok;
    logic          in_ovf_set;
    logic          pop;
    logic          fifo_wr;
    logic          out_ovf_set;
    logic          frame_set;
    logic [2:0]    w1c;
    logic [CW-1:0] in_inc;
    logic [CW-1:0] out_inc;
    logic [CW-1:0] in_nxt;
    logic [CW-1:0] out_nxt;
    logic [DWL-1:0] rd_val;

    logic unused_wdata;
    assign unused_wdata = ^WDATA[DWL-1:6];

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign head       = mem[rptr[FIFO_AW-1:0]];
    assign IRQ        = frame_done;

    // Decode host accesses and derive push/pop/flag events for this cycle;
    // soft clear overrides any push or capture in the same cycle.
    always_comb begin
        wr_in_r     = WR && (ADDR == 3'd0);
        wr_in_i     = WR && (ADDR == 3'd1);
        wr_status   = WR && (ADDR == 3'd4);
        wr_ctrl     = WR && (ADDR == 3'd7);
        push_req    = (wr_in_i && push_on_imag) || (wr_ctrl && WDATA[1]);
        soft_clr    = wr_ctrl && WDATA[2];
        push_ok     = push_req && !i_FULL && !soft_clr;
        in_ovf_set  = push_req && i_FULL && !soft_clr;
        pop         = RD && (ADDR == 3'd3) && !fifo_empty;
        fifo_wr     = i_VALID && (!fifo_full || pop);
        out_ovf_set = i_VALID && fifo_full && !pop;
        w1c         = wr_status ? WDATA[5:3] : 3'b000;
        in_inc      = in_cnt + CW'(1);
        out_inc     = out_cnt + CW'(1);
        in_nxt      = (in_inc == FRAME) ? '0 : in_inc;
        out_nxt     = (out_inc == FRAME) ? '0 : out_inc;
        frame_set   = i_VALID && (out_inc == FRAME);
    end

    // Read data mux; counters are zero-extended, empty FIFO reads as 0.
    always_comb begin
        rd_val = '0;
        unique case (ADDR)
            3'd0: rd_val = o_DATA_R;
            3'd1: rd_val = o_DATA_I;
            3'd2: rd_val = fifo_empty ? '0 : head[2*DWL-1:DWL];
            3'd3: rd_val = fifo_empty ? '0 : head[DWL-1:0];
            3'd4: rd_val[5:0] = {frame_done, out_ovf, in_ovf,
                                 fifo_full, fifo_empty, i_FULL};
            3'd5: rd_val[CW-1:0] = in_cnt;
            3'd6: rd_val[CW-1:0] = out_cnt;
            3'd7: rd_val[0] = push_on_imag;
            default: rd_val = '0;
        endcase
    end

    // Sample latches, CTRL bit and the one-cycle push strobe to the core.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_DATA_R     <= '0;
            o_DATA_I     <= '0;
            push_on_imag <= 1'b1;
            o_WR_DATA    <= 1'b0;
        end else begin
            if (wr_in_r) o_DATA_R <= WDATA;
            if (wr_in_i) o_DATA_I <= WDATA;
            if (wr_ctrl) push_on_imag <= WDATA[0];
            o_WR_DATA <= push_ok;
        end
    end

    // Sample counters; OUT_CNT advances on every VALID to keep frame alignment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (soft_clr) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push_ok) in_cnt <= in_nxt;
            if (i_VALID) out_cnt <= out_nxt;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_ovf     <= 1'b0;
            out_ovf    <= 1'b0;
            frame_done <= 1'b0;
        end else if (soft_clr) begin
            in_ovf     <= 1'b0;
            out_ovf    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            in_ovf     <= in_ovf_set  | (in_ovf     & ~w1c[0]);
            out_ovf    <= out_ovf_set | (out_ovf    & ~w1c[1]);
            frame_done <= frame_set   | (frame_done & ~w1c[2]);
        end
    end

    // FIFO pointers with wrap bit; soft clear flushes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else if (soft_clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (fifo_wr) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage write of the captured result pair.
    always_ff @(posedge CLK) begin
        if (fifo_wr && !soft_clr) mem[wptr[FIFO_AW-1:0]] <= {i_DATA_R, i_DATA_I};
    end

    // Registered read data, held between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) RDATA <= '0;
        else if (RD) RDATA <= rd_val;
    end

endmodule
